// File: rtl/wfifo_pkt_writer.sv
// Write-side packet admission controller for the asynchronous FIFO.
// A packet is admitted only when the space its declared length needs is free.
// The packet's beats then pass straight through to winc/wdata, with wfull as
// back-pressure.
module wfifo_pkt_writer #(
  parameter int unsigned ADDRSIZE    = 4,
  parameter int unsigned DSIZE       = 8,
  parameter int unsigned LENW        = 5,
  parameter int unsigned AFULL_LEVEL = 12
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                s_valid,
  input  logic [DSIZE-1:0]    s_data,
  input  logic                s_last,
  input  logic [LENW-1:0]     s_len,
  output logic                s_ready,
  output logic                winc,
  output logic [DSIZE-1:0]    wdata,
  input  logic                wfull,
  input  logic [ADDRSIZE:0]   wptr,
  input  logic [ADDRSIZE:0]   wrptr2,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                walmost_full,
  output logic                pkt_done,
  output logic                err_len
);

  localparam int unsigned PW    = ADDRSIZE + 1;
  localparam int unsigned DEPTH = 1 << ADDRSIZE;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] BURST = 2'd2;

  // Gray to binary: each binary bit is the xor of all gray bits at or above it
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = '0;
    for (int i = 0; i < int'(PW); i++) b[i] = ^(g >> i);
    return b;
  endfunction

  logic [1:0]      state_q, state_d;
  logic [LENW-1:0] len_q, len_d;
  logic [PW-1:0]   req_q, req_d;
  logic [LENW-1:0] cnt_q, cnt_d;
  logic [LENW-1:0] cnt_inc;
  logic            done_d, err_d;

  logic [PW-1:0]   wbin, rbin, lvl, free, req;
  logic            len_zero, len_big;

  // Conservative fill level; wrptr2 is stale, so lvl can only overestimate
  assign wbin = gray2bin(wptr);
  assign rbin = gray2bin(wrptr2);
  assign lvl  = wbin - rbin;
  assign free = PW'(DEPTH) - lvl;

  // Required space: the declared length clamped to 1..DEPTH
  assign len_zero = (s_len == '0);
  assign len_big  = (32'(s_len) > DEPTH);
  assign req      = len_zero ? PW'(1) : (len_big ? PW'(DEPTH) : PW'(s_len));

  // Beat handshake is combinational so that data reaches memory with no added latency
  assign s_ready = (state_q == BURST) && !wfull;
  assign winc    = s_valid && s_ready;
  assign wdata   = s_data;

  assign cnt_inc = cnt_q + LENW'(1);

  // Next-state and next-register logic for the admission FSM
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_valid) begin
          len_d   = s_len;
          req_d   = req;
          err_d   = len_zero || len_big;
          state_d = (free >= req) ? BURST : WAIT;
        end
      end
      WAIT: begin
        if (free >= req_q) state_d = BURST;
      end
      BURST: begin
        if (winc) begin
          cnt_d = cnt_inc;
          if (s_last) begin
            done_d  = 1'b1;
            err_d   = (cnt_inc != len_q);
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, packet context, status pulses and the lagged level
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q      <= IDLE;
      len_q        <= '0;
      req_q        <= '0;
      cnt_q        <= '0;
      pkt_done     <= 1'b0;
      err_len      <= 1'b0;
      wlevel       <= '0;
      walmost_full <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      req_q        <= req_d;
      cnt_q        <= cnt_d;
      pkt_done     <= done_d;
      err_len      <= err_d;
      wlevel       <= lvl;
      walmost_full <= (lvl >= PW'(AFULL_LEVEL));
    end
  end

endmodule

// File: tb/tb_wfifo_pkt_writer.sv
// Self-checking bench for wfifo_pkt_writer with a behavioural pointer stage
// and a data scoreboard.
module tb_wfifo_pkt_writer;

  logic       wclk = 1'b0;
  logic       wrst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_last = 1'b0;
  logic [4:0] s_len = '0;
  logic       s_ready, winc, wfull;
  logic [7:0] wdata;
  logic [4:0] wptr, wrptr2, wlevel;
  logic       walmost_full, pkt_done, err_len;

  logic [4:0] wbin_m = '0, rbin_m = '0, ld_w = '0, ld_r = '0;
  logic       load = 1'b0, force_full = 1'b0;

  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;

  wfifo_pkt_writer #(.ADDRSIZE(4), .DSIZE(8), .LENW(5), .AFULL_LEVEL(12)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .s_valid(s_valid), .s_data(s_data),
    .s_last(s_last), .s_len(s_len), .s_ready(s_ready), .winc(winc),
    .wdata(wdata), .wfull(wfull), .wptr(wptr), .wrptr2(wrptr2),
    .wlevel(wlevel), .walmost_full(walmost_full), .pkt_done(pkt_done),
    .err_len(err_len)
  );

  always #5 wclk = ~wclk;

  // Pointer stage model: write pointer advances one cycle after winc
  always @(posedge wclk) begin
    if (load) begin
      wbin_m <= ld_w;
      rbin_m <= ld_r;
    end else if (winc) begin
      wbin_m <= wbin_m + 5'd1;
    end
  end

  assign wptr   = wbin_m ^ (wbin_m >> 1);
  assign wrptr2 = rbin_m ^ (rbin_m >> 1);
  assign wfull  = force_full || ((wbin_m - rbin_m) == 5'd16);

  task automatic load_ptrs(input logic [4:0] w, input logic [4:0] r);
    @(posedge wclk); #1;
    load = 1'b1; ld_w = w; ld_r = r;
    @(posedge wclk); #1;
    load = 1'b0;
  endtask

  // Drives one packet beat by beat; the scoreboard pops at every accepted beat
  task automatic send_pkt(input logic [4:0] len, input int nbeats, input logic [7:0] base,
                          input logic with_last, input int stall_at, input int stall_len,
                          output int first_wait, output int stalls, output logic err_first);
    int waits;
    int rem;
    logic [7:0] exp_d;
    first_wait = 0; stalls = 0; err_first = 1'b0; rem = 0;
    for (int i = 0; i < nbeats; i++) begin
      s_valid = 1'b1; s_data = base + 8'(i); s_len = len;
      s_last = with_last && (i == nbeats - 1);
      exp_q.push_back(s_data);
      if (i == stall_at) begin force_full = 1'b1; rem = stall_len; end
      waits = 0;
      forever begin
        @(negedge wclk);
        n_checks++;
        if (winc && wfull) $display("FAIL winc_while_full: winc=%0b wfull=%0b required winc=0", winc, wfull);
        else n_pass++;
        if (s_valid && s_ready) break;
        waits++;
        if (waits > 100) begin
          n_checks++;
          $display("FAIL beat_timeout: beat %0d not accepted after %0d cycles, required acceptance", i, waits);
          s_valid = 1'b0; s_last = 1'b0; force_full = 1'b0;
          return;
        end
        if (force_full && rem > 0) begin
          rem--;
          if (rem == 0) begin @(posedge wclk); #1; force_full = 1'b0; end
        end
      end
      if (i == 0) begin first_wait = waits; err_first = err_len; end
      else stalls += waits;
      exp_d = exp_q.pop_front();
      n_checks++;
      if (!winc || wdata !== exp_d) $display("FAIL beat_data[%0d]: winc=%0b wdata=%h required 1/%h", i, winc, wdata, exp_d);
      else n_pass++;
      @(posedge wclk); #1;
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic test_reset;
    wrst_n = 1'b0; s_valid = 1'b1; s_len = 5'd2;
    load = 1'b1; ld_w = '0; ld_r = '0;
    repeat (2) @(posedge wclk); #1;
    load = 1'b0;
    n_checks++; if (s_ready !== 1'b0) $display("FAIL reset_s_ready: got %0b required 0", s_ready); else n_pass++;
    n_checks++; if (winc !== 1'b0) $display("FAIL reset_winc: got %0b required 0", winc); else n_pass++;
    n_checks++; if (wlevel !== 5'd0) $display("FAIL reset_wlevel: got %0d required 0", wlevel); else n_pass++;
    n_checks++; if (walmost_full !== 1'b0) $display("FAIL reset_afull: got %0b required 0", walmost_full); else n_pass++;
    n_checks++; if (pkt_done !== 1'b0) $display("FAIL reset_pkt_done: got %0b required 0", pkt_done); else n_pass++;
    n_checks++; if (err_len !== 1'b0) $display("FAIL reset_err_len: got %0b required 0", err_len); else n_pass++;
    s_valid = 1'b0;
    @(negedge wclk); wrst_n = 1'b1;
    @(posedge wclk); #1;
  endtask

  task automatic test_basic;
    int fw, st; logic ef;
    send_pkt(5'd4, 4, 8'hA0, 1'b1, -1, 0, fw, st, ef);
    n_checks++; if (fw != 1) $display("FAIL basic_bubble: got %0d required 1", fw); else n_pass++;
    n_checks++; if (st != 0) $display("FAIL basic_stalls: got %0d required 0", st); else n_pass++;
    n_checks++; if (pkt_done !== 1'b1 || err_len !== 1'b0) $display("FAIL basic_done: done=%0b err=%0b required 1/0", pkt_done, err_len); else n_pass++;
    @(posedge wclk); #1;
    n_checks++; if (wlevel !== 5'd4) $display("FAIL basic_wlevel: got %0d required 4", wlevel); else n_pass++;
    n_checks++; if (pkt_done !== 1'b0 || walmost_full !== 1'b0) $display("FAIL basic_after: done=%0b afull=%0b required 0/0", pkt_done, walmost_full); else n_pass++;
  endtask

  task automatic test_wait_space;
    int fw, st; logic ef;
    load_ptrs(5'd14, 5'd0);
    s_valid = 1'b1; s_len = 5'd4; s_data = 8'hB0; s_last = 1'b0;
    repeat (5) begin
      @(negedge wclk);
      n_checks++; if (s_ready !== 1'b0 || winc !== 1'b0) $display("FAIL wait_hold: s_ready=%0b winc=%0b required 0/0", s_ready, winc); else n_pass++;
    end
    load_ptrs(5'd14, 5'd2);
    send_pkt(5'd4, 4, 8'hB0, 1'b1, -1, 0, fw, st, ef);
    n_checks++; if (pkt_done !== 1'b1 || err_len !== 1'b0) $display("FAIL wait_done: done=%0b err=%0b required 1/0", pkt_done, err_len); else n_pass++;
    @(posedge wclk); #1;
    n_checks++; if (wlevel !== 5'd16 || walmost_full !== 1'b1) $display("FAIL wait_level: wlevel=%0d afull=%0b required 16/1", wlevel, walmost_full); else n_pass++;
  endtask

  task automatic test_full_stall;
    int fw, st; logic ef;
    load_ptrs(5'd12, 5'd0);
    send_pkt(5'd4, 4, 8'hC0, 1'b1, 1, 3, fw, st, ef);
    n_checks++; if (st != 3) $display("FAIL stall_cycles: got %0d required 3", st); else n_pass++;
    n_checks++; if (pkt_done !== 1'b1 || err_len !== 1'b0) $display("FAIL stall_done: done=%0b err=%0b required 1/0", pkt_done, err_len); else n_pass++;
    n_checks++; if (wbin_m !== 5'd16) $display("FAIL stall_total_beats: wbin=%0d required 16", wbin_m); else n_pass++;
  endtask

  task automatic test_len_err;
    int fw, st; logic ef;
    load_ptrs(5'd0, 5'd0);
    send_pkt(5'd3, 5, 8'hD0, 1'b1, -1, 0, fw, st, ef);
    n_checks++; if (ef !== 1'b0) $display("FAIL len3_idle_err: got %0b required 0", ef); else n_pass++;
    n_checks++; if (pkt_done !== 1'b1 || err_len !== 1'b1) $display("FAIL len3_long: done=%0b err=%0b required 1/1", pkt_done, err_len); else n_pass++;
    load_ptrs(5'd0, 5'd0);
    send_pkt(5'd20, 2, 8'h70, 1'b1, -1, 0, fw, st, ef);
    n_checks++; if (ef !== 1'b1 || fw != 1) $display("FAIL len20_clamp: err=%0b wait=%0d required 1/1", ef, fw); else n_pass++;
    n_checks++; if (pkt_done !== 1'b1 || err_len !== 1'b1) $display("FAIL len20_done: done=%0b err=%0b required 1/1", pkt_done, err_len); else n_pass++;
    load_ptrs(5'd15, 5'd0);
    send_pkt(5'd0, 1, 8'hE0, 1'b1, -1, 0, fw, st, ef);
    n_checks++; if (ef !== 1'b1 || fw != 1) $display("FAIL len0_admit: err=%0b wait=%0d required 1/1", ef, fw); else n_pass++;
    n_checks++; if (pkt_done !== 1'b1 || err_len !== 1'b1) $display("FAIL len0_done: done=%0b err=%0b required 1/1", pkt_done, err_len); else n_pass++;
  endtask

  task automatic test_wrap;
    int fw, st; logic ef;
    load_ptrs(5'd16, 5'd0);
    @(posedge wclk); #1;
    n_checks++; if (wlevel !== 5'd16 || walmost_full !== 1'b1) $display("FAIL wrap_full_level: wlevel=%0d afull=%0b required 16/1", wlevel, walmost_full); else n_pass++;
    s_valid = 1'b1; s_len = 5'd1; s_data = 8'hF0; s_last = 1'b1;
    repeat (4) begin
      @(negedge wclk);
      n_checks++; if (s_ready !== 1'b0) $display("FAIL wrap_wait: s_ready=%0b required 0", s_ready); else n_pass++;
    end
    load_ptrs(5'd16, 5'd1);
    send_pkt(5'd1, 1, 8'hF0, 1'b1, -1, 0, fw, st, ef);
    n_checks++; if (pkt_done !== 1'b1 || err_len !== 1'b0) $display("FAIL single_beat: done=%0b err=%0b required 1/0", pkt_done, err_len); else n_pass++;
    load_ptrs(5'd3, 5'd25);
    @(posedge wclk); #1;
    n_checks++; if (wlevel !== 5'd10 || walmost_full !== 1'b0) $display("FAIL wrap_mod: wlevel=%0d afull=%0b required 10/0", wlevel, walmost_full); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int fw, st; logic ef;
    load_ptrs(5'd0, 5'd0);
    send_pkt(5'd1, 1, 8'h10, 1'b1, -1, 0, fw, st, ef);
    n_checks++; if (pkt_done !== 1'b1) $display("FAIL b2b_first_done: got %0b required 1", pkt_done); else n_pass++;
    send_pkt(5'd2, 2, 8'h20, 1'b1, -1, 0, fw, st, ef);
    n_checks++; if (fw != 1 || st != 0) $display("FAIL b2b_gap: wait=%0d stalls=%0d required 1/0", fw, st); else n_pass++;
    n_checks++; if (pkt_done !== 1'b1 || err_len !== 1'b0) $display("FAIL b2b_done: done=%0b err=%0b required 1/0", pkt_done, err_len); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int fw, st; logic ef;
    load_ptrs(5'd0, 5'd0);
    send_pkt(5'd6, 2, 8'h90, 1'b0, -1, 0, fw, st, ef);
    s_valid = 1'b1; s_data = 8'h92; s_len = 5'd6;
    n_checks++; if (s_ready !== 1'b1 || winc !== 1'b1) $display("FAIL mid_pre_reset: s_ready=%0b winc=%0b required 1/1", s_ready, winc); else n_pass++;
    #1 wrst_n = 1'b0;
    #1;
    n_checks++; if (s_ready !== 1'b0 || winc !== 1'b0) $display("FAIL mid_reset_hs: s_ready=%0b winc=%0b required 0/0", s_ready, winc); else n_pass++;
    n_checks++; if (wlevel !== 5'd0 || walmost_full !== 1'b0 || pkt_done !== 1'b0 || err_len !== 1'b0)
      $display("FAIL mid_reset_regs: wlevel=%0d afull=%0b done=%0b err=%0b required 0/0/0/0", wlevel, walmost_full, pkt_done, err_len);
    else n_pass++;
    s_valid = 1'b0;
    repeat (2) @(posedge wclk);
    @(negedge wclk); wrst_n = 1'b1;
    repeat (3) begin
      @(negedge wclk);
      n_checks++; if (pkt_done !== 1'b0) $display("FAIL mid_no_done: got %0b required 0", pkt_done); else n_pass++;
    end
    n_checks++; if (wlevel !== 5'd2) $display("FAIL mid_kept_beats: wlevel=%0d required 2", wlevel); else n_pass++;
    @(posedge wclk); #1;
    send_pkt(5'd2, 2, 8'hA8, 1'b1, -1, 0, fw, st, ef);
    n_checks++; if (fw != 1 || pkt_done !== 1'b1 || err_len !== 1'b0) $display("FAIL mid_readmit: wait=%0d done=%0b err=%0b required 1/1/0", fw, pkt_done, err_len); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_space();
    test_full_stall();
    test_len_err();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wfifo_pkt_writer.md
# wfifo_pkt_writer

Write-side packet admission controller for the asynchronous FIFO, running in the write clock domain. It sits directly upstream of the write-pointer/full-flag stage. It accepts a valid/ready packet stream and computes the FIFO fill level from the gray write pointer and the synchronized gray read pointer. A packet is admitted only when the whole declared length fits, then its beats are driven onto winc/wdata.

## Interface
- ADDRSIZE, 4, FIFO address width; DEPTH = 2^ADDRSIZE
- DSIZE, 8, data width
- LENW, 5, width of the packet-length field
- AFULL_LEVEL, 12, almost-full threshold in words
- wclk  in  1  write clock
- wrst_n  in  1  reset wrst_n, asynchronous, active-low; clock wclk
- s_valid  in  1  upstream beat valid
- s_data  in  DSIZE  upstream beat data
- s_last  in  1  final beat of packet
- s_len  in  LENW  packet length in beats; meaningful on the first beat only
- s_ready  out  1  beat accepted when s_valid && s_ready
- winc  out  1  write strobe to pointer stage
- wdata  out  DSIZE  write data to FIFO memory
- wfull  in  1  full flag from pointer stage
- wptr  in  ADDRSIZE+1  gray write pointer from pointer stage
- wrptr2  in  ADDRSIZE+1  gray read pointer, synchronized into wclk
- wlevel  out  ADDRSIZE+1  registered fill level, 0..DEPTH
- walmost_full  out  1  registered, wlevel >= AFULL_LEVEL
- pkt_done  out  1  one-cycle pulse when the last beat is accepted
- err_len  out  1  one-cycle pulse on a length violation

## Operation
- Level: convert wptr and wrptr2 gray-to-binary. lvl = (wbin - rbin) mod 2^(ADDRSIZE+1). free = DEPTH - lvl. Both are combinational and conservative, because wrptr2 is stale.
- Required space: req = s_len clamped to 1..DEPTH.
  - s_len == 0 gives req = 1 and err_len.
  - s_len > DEPTH gives req = DEPTH and err_len.
- FSM states:
  - IDLE: s_ready = 0. When s_valid is high, latch s_len into len_q and req into req_q. Go to BURST if free >= req, else go to WAIT.
  - WAIT: s_ready = 0. Re-evaluate free >= req_q every cycle; go to BURST when true.
  - BURST: s_ready = !wfull. Each accepted beat increments beat_cnt. An accepted beat with s_last pulses pkt_done, returns to IDLE and clears beat_cnt. If beat_cnt + 1 != len_q on that beat, err_len also pulses.
- Beats beyond len_q are still written. wfull back-pressure protects the FIFO.
- winc = s_valid && s_ready and wdata = s_data, both combinational, with zero added latency. winc is never high while wfull = 1.
- Upstream holds s_valid, s_data, s_len and s_last stable until accepted.

## Timing
- Reset values: FSM = IDLE, beat_cnt = 0, s_ready = 0, winc = 0, wlevel = 0, walmost_full = 0, pkt_done = 0, err_len = 0.
- Admission bubble: the first beat is accepted no earlier than 1 cycle after s_valid is seen in IDLE.
- Back-to-back packets have one idle cycle between them (the IDLE state).
- wlevel and walmost_full lag lvl by 1 cycle.
- wptr reflects the previous cycle's winc. Free space seen in IDLE therefore includes every beat already written, so admission is never optimistic.
- wfull asserted mid-burst: s_ready drops in the same cycle, state stays BURST, beat_cnt holds. Writing resumes on the first cycle with wfull = 0.
- Pointer wrap: the subtraction is mod 2^(ADDRSIZE+1). A full FIFO (MSBs differ, rest equal) gives lvl = DEPTH. Equal pointers give 0.
- Reset mid-packet: return to IDLE immediately. Beats already written stay in the FIFO. No pkt_done is issued.
- s_last on the first BURST beat with len_q = 1 is a legal single-beat packet: pkt_done pulses, err_len does not.

## Test plan
- Empty FIFO, DEPTH 16, 4-beat packet (s_len = 4, data 0xA0..0xA3) -> 4 consecutive winc starting 1 cycle after s_valid, pkt_done on beat 4, wlevel = 4 two cycles later, no err_len.
- 14 words resident, rptr frozen, s_len = 4 -> FSM holds WAIT, s_ready = 0. Advance wrptr2 by 2 (free = 4) -> BURST, 4 beats written, wlevel = 16, walmost_full = 1.
- 12 words resident, force wfull high for 3 cycles in mid-burst -> winc = 0 for exactly those 3 cycles, beat order preserved, total beats = s_len.
- s_len = 3 but s_last on beat 5 -> 5 winc pulses, pkt_done and err_len pulse together on beat 5. s_len = 0 -> err_len in IDLE, a 1-word space check, packet still written.
- wptr = 5'b11000, wrptr2 = 5'b00000 (gray; wbin = 16, rbin = 0, wrapped) -> wlevel = 16, free = 0, packet with s_len = 1 waits in WAIT.
- Deassert wrst_n after beat 2 of 6 -> all outputs 0 asynchronously, FSM = IDLE. After release, a new packet is admitted normally.
